// File: rtl/mat4_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mat4_loader
// Brief    : Loads 16 signed bytes into a packed 4x4 matrix, waits DET_LAT
//            cycles, then captures the downstream determinant and overflow.
//            Define STICKY_OVF_EN to add an accumulated overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module mat4_loader #(
    parameter int DET_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    output logic [127:0] mat_out,
    output logic         mat_valid,
    input  logic [7:0]   det_in,
    input  logic         ovf_in,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [7:0]   res_det,
    output logic         res_ovf,
    output logic         busy,
    output logic         ovf_sticky
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam logic [3:0] c_WAIT_INIT = 4'(DET_LAT - 1);

    state_t       r_state;
    logic [3:0]   r_idx;
    logic [3:0]   r_cnt;
    logic [127:0] r_mat;
    logic         r_mat_valid;
    logic         r_res_valid;
    logic [7:0]   r_res_det;
    logic         r_res_ovf;

    logic         w_accept;
    logic [6:0]   w_lsb;

    assign in_ready  = rst_n && (r_state == S_LOAD);
    assign busy      = rst_n && (r_state != S_LOAD);
    assign w_accept  = in_valid && in_ready;
    // Element idx lives at bits [127-8*idx -: 8], i.e. LSB at 8*(15-idx).
    assign w_lsb     = {~r_idx, 3'b000};

    assign mat_out   = r_mat;
    assign mat_valid = r_mat_valid;
    assign res_valid = r_res_valid;
    assign res_det   = r_res_det;
    assign res_ovf   = r_res_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_LOAD;
            r_idx       <= 4'd0;
            r_cnt       <= 4'd0;
            r_mat       <= 128'd0;
            r_mat_valid <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_det   <= 8'd0;
            r_res_ovf   <= 1'b0;
        end else begin
            r_mat_valid <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        r_mat[w_lsb +: 8] <= in_data;
                        r_idx             <= r_idx + 4'd1;
                        if (r_idx == 4'd15) begin
                            r_state     <= S_WAIT;
                            r_cnt       <= c_WAIT_INIT;
                            r_mat_valid <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_res_det   <= det_in;
                        r_res_ovf   <= ovf_in;
                        r_res_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_LOAD;
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

`ifdef STICKY_OVF_EN
    logic r_ovf_sticky;
    logic w_capture;

    assign w_capture  = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign ovf_sticky = r_ovf_sticky;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_capture && ovf_in) begin
            r_ovf_sticky <= 1'b1;
        end
    end
`else
    assign ovf_sticky = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mat4_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mat4_loader
// Brief    : Directed bench for mat4_loader with a registered 4x4 det stub and
//            a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mat4_loader;

    localparam int c_LAT = 2;
`ifdef STICKY_OVF_EN
    localparam bit c_STICKY = 1'b1;
`else
    localparam bit c_STICKY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = 8'd0;
    logic [127:0] mat_out;
    logic         mat_valid;
    logic [7:0]   det_in = 8'd0;
    logic         ovf_in = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [7:0]   res_det;
    logic         res_ovf;
    logic         busy;
    logic         ovf_sticky;

    typedef struct {
        logic [127:0] mat;
        logic [7:0]   det;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   acc_cnt  = 0;
    int   mv_cnt   = 0;
    int   acc0, mv0;
    bit   exp_sticky = 1'b0;

    mat4_loader #(.DET_LAT(c_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mat_out    (mat_out),
        .mat_valid  (mat_valid),
        .det_in     (det_in),
        .ovf_in     (ovf_in),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_det    (res_det),
        .res_ovf    (res_ovf),
        .busy       (busy),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    function automatic int det3(int a, int b, int c, int d, int e, int f,
                                int g, int h, int i);
        return a * (e * i - f * h) - b * (d * i - f * g) + c * (d * h - e * g);
    endfunction

    function automatic int det4(logic [127:0] m);
        int x[16];
        for (int k = 0; k < 16; k++) x[k] = int'($signed(m[127 - 8*k -: 8]));
        return x[0] * det3(x[5], x[6], x[7], x[9], x[10], x[11], x[13], x[14], x[15])
             - x[1] * det3(x[4], x[6], x[7], x[8], x[10], x[11], x[12], x[14], x[15])
             + x[2] * det3(x[4], x[5], x[7], x[8], x[9], x[11], x[12], x[13], x[15])
             - x[3] * det3(x[4], x[5], x[6], x[8], x[9], x[10], x[12], x[13], x[14]);
    endfunction

    // Registered determinant stage standing in for the downstream block.
    always @(posedge clk) begin
        det_in <= 8'(det4(mat_out));
        ovf_in <= (det4(mat_out) > 127) || (det4(mat_out) < -128);
    end

    always @(posedge clk) if (in_valid && in_ready) acc_cnt++;
    always @(negedge clk) if (mat_valid) mv_cnt++;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_elem(input logic [7:0] d);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_timeout", 128'(t < 100), 128'd1);
        @(negedge clk);
    endtask

    task automatic send_matrix(input logic [127:0] m, input int gap, input bit keep,
                               input logic [7:0] det, input logic ovf);
        exp_t e;
        e.mat = m;
        e.det = det;
        e.ovf = ovf;
        sb.push_back(e);
        acc0 = acc_cnt;
        mv0  = mv_cnt;
        for (int i = 0; i < 16; i++) begin
            send_elem(m[127 - 8*i -: 8]);
            if (i < 15 && gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        chk("mat_valid_pulse", 128'(mat_valid), 128'd1);
        if (keep) begin
            in_valid = 1'b1;
            in_data  = 8'hA5;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic get_result(input int hold);
        int   t = 0;
        exp_t e;
        while (!res_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("result_latency", 128'(t), 128'(c_LAT));
        chk("sb_nonempty", 128'(sb.size() > 0), 128'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            exp_sticky = exp_sticky | (e.ovf & c_STICKY);
            chk("res_det", 128'(res_det), 128'(e.det));
            chk("res_ovf", 128'(res_ovf), 128'(e.ovf));
            chk("mat_out", mat_out, e.mat);
            chk("busy_out", 128'(busy), 128'd1);
            chk("in_ready_out", 128'(in_ready), 128'd0);
            chk("ovf_sticky", 128'(ovf_sticky), 128'(exp_sticky));
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                chk("hold_valid", 128'(res_valid), 128'd1);
                chk("hold_det", 128'(res_det), 128'(e.det));
                chk("hold_in_ready", 128'(in_ready), 128'd0);
                chk("hold_mat", mat_out, e.mat);
            end
        end
        res_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_clear", 128'(res_valid), 128'd0);
        chk("in_ready_back", 128'(in_ready), 128'd1);
        chk("busy_clear", 128'(busy), 128'd0);
        chk("accept_count", 128'(acc_cnt - acc0), 128'd16);
        chk("mat_valid_count", 128'(mv_cnt - mv0), 128'd1);
    endtask

    initial begin
        logic [127:0] m_id, m_d4, m_d2, m_seq, m_part;
        m_id  = 128'h01000000_00010000_00000100_00000001;
        m_d4  = 128'h04000000_00040000_00000400_00000004;
        m_d2  = 128'h02000000_00020000_00000200_00000002;
        m_seq = 128'h01020304_05060708_090A0B0C_0D0E0F10;
        m_part = 128'h11223344_55667788_99AABBCC_DDEEFF00;

        repeat (3) @(negedge clk);
        chk("rst_mat_out", mat_out, 128'd0);
        chk("rst_mat_valid", 128'(mat_valid), 128'd0);
        chk("rst_res_valid", 128'(res_valid), 128'd0);
        chk("rst_res_det", 128'(res_det), 128'd0);
        chk("rst_res_ovf", 128'(res_ovf), 128'd0);
        chk("rst_sticky", 128'(ovf_sticky), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 128'(in_ready), 128'd1);

        send_matrix(m_id, 0, 1'b0, 8'h01, 1'b0);
        get_result(0);

        send_matrix(m_d4, 0, 1'b0, 8'h00, 1'b1);
        get_result(0);

        // in_valid stays high through WAIT and OUT; nothing may be accepted.
        send_matrix(m_id, 0, 1'b1, 8'h01, 1'b0);
        get_result(0);

        send_matrix(m_seq, 1, 1'b0, 8'h00, 1'b0);
        get_result(0);

        send_matrix(m_d2, 0, 1'b0, 8'h10, 1'b0);
        get_result(5);

        for (int i = 0; i < 7; i++) send_elem(m_part[127 - 8*i -: 8]);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        exp_sticky = 1'b0;
        chk("midrst_in_ready", 128'(in_ready), 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_mat_out", mat_out, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_sticky", 128'(ovf_sticky), 128'd0);
        send_matrix(m_id, 0, 1'b0, 8'h01, 1'b0);
        get_result(0);

        chk("sb_drained", 128'(sb.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mat4_loader.md
MAT4_LOADER -- requirements
Module: mat4_loader

Interface
REQ-001 Parameter DET_LAT, default 2, cycles from the matrix becoming stable to the det_in/ovf_in capture; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 in_valid  input  1  upstream element valid.
REQ-005 in_ready  output  1  loader accepts an element this cycle.
REQ-006 in_data  input  8  signed element, row-major order a..p.
REQ-007 mat_out  output  128  packed matrix; element 0 in [127:120], element 15 in [7:0].
REQ-008 mat_valid  output  1  one-cycle pulse when mat_out holds a complete new matrix.
REQ-009 det_in  input  8  signed determinant from the downstream det stage.
REQ-010 ovf_in  input  1  overflow flag from the downstream det stage.
REQ-011 res_valid  output  1  result available.
REQ-012 res_ready  input  1  consumer accepts the result.
REQ-013 res_det  output  8  captured determinant.
REQ-014 res_ovf  output  1  captured overflow flag.
REQ-015 busy  output  1  high whenever state is not LOAD.
REQ-016 ovf_sticky  output  1  accumulated overflow; see Configuration.

Function
REQ-017 The FSM SHALL have exactly three states: LOAD, WAIT and OUT.
REQ-018 LOAD: in_ready=1; on in_valid&in_ready, write in_data into byte slot idx (bits [127-8*idx -: 8]) and increment the 4-bit idx.
REQ-019 On acceptance with idx==15: go to WAIT, wrap idx to 0, load the wait counter with DET_LAT-1, and assert mat_valid in the next cycle only.
REQ-020 mat_out SHALL update only on element acceptance, so it stays stable throughout WAIT and OUT.
REQ-021 WAIT: in_ready=0; decrement the counter each cycle; when it reaches 0, register det_in to res_det and ovf_in to res_ovf, then go to OUT.
REQ-022 With DET_LAT=2, the capture edge SHALL be the second rising edge after the edge that wrote element 15.
REQ-023 OUT: res_valid=1; res_det and res_ovf held constant; in_ready=0; on res_ready, go to LOAD with res_valid=0 the next cycle.
REQ-024 res_valid and res_ready both high in the same cycle SHALL complete the transfer; no result is dropped or duplicated.
REQ-025 in_valid asserted outside LOAD SHALL be ignored, with no state change.
REQ-026 res_ready asserted outside OUT SHALL be ignored.
REQ-027 No arithmetic is performed on the data; det_in and ovf_in pass through unmodified.

Reset
REQ-028 With rst_n=0 at a rising edge: state=LOAD, idx=0, wait counter=0, mat_out=0, mat_valid=0, res_valid=0, res_det=0, res_ovf=0, ovf_sticky=0.
REQ-029 While in reset, in_ready=0 and busy=0.
REQ-030 Reset asserted mid-load, in WAIT or in OUT SHALL discard the partial matrix or pending result; loading restarts at element 0.

Configuration
REQ-031 Macro STICKY_OVF_EN defined: ovf_sticky is set when a result is captured with ovf_in=1, and is cleared only by reset.
REQ-032 Macro STICKY_OVF_EN undefined: ovf_sticky is tied to 0 and no sticky register exists; all other behaviour is identical.

Verification (det stub = registered 4x4 determinant, DET_LAT=2)
REQ-033 Identity matrix, res_ready=1 -> mat_out=0x01000000_00010000_00000100_00000001, res_det=0x01, res_ovf=0.
REQ-034 diag(4,4,4,4) -> res_det=0x00, res_ovf=1; ovf_sticky=1 with the macro and stays 1 over a following identity matrix; ovf_sticky=0 without the macro.
REQ-035 Elements 1..16 with in_valid toggling every other cycle -> 16 acceptances, one mat_valid pulse, res_det=0x00, res_ovf=0.
REQ-036 diag(2,2,2,2) with res_ready=0 for 5 cycles -> res_valid=1 and res_det=0x10 held for all 5 cycles, in_ready=0, next matrix accepted only after the handshake.
REQ-037 rst_n=0 for one cycle after 7 elements are accepted -> idx=0 and mat_out=0; a following full identity load yields res_det=0x01.
REQ-038 in_valid held high during WAIT and OUT -> no element accepted and mat_out unchanged until the state returns to LOAD.
